// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, bit-order selectors and the
// debug view the shift engine exports for checkers.
package spi_pkg;

  typedef logic state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;

  localparam int MSB_FIRST       = 0;
  localparam int LSB_FIRST_ORDER = 1;

  // Widest legal frame; sizes the debug bit-count field for every instance.
  localparam int MAX_WIDTH   = 32;
  localparam int DBG_COUNT_W = $clog2(MAX_WIDTH + 1);

  typedef struct packed {
    state_t                 state;
    logic [DBG_COUNT_W-1:0] bit_count;
  } spi_dbg_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Frame-level bus between the SPI register/FSM layer plus edge detector
// (master) and the shift engine (slave).
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  import spi_pkg::*;

  // start is a one-cycle request that is only accepted while busy is low;
  // every accepted start yields exactly one done pulse unless reset intervenes.
  // sampleEdge/launchEdge are one-cycle strobes with no back-pressure; they
  // are ignored while busy is low.
  logic             start;
  logic [WIDTH-1:0] parallelDataIn;
  logic             sampleEdge;
  logic             launchEdge;
  logic             serialDataIn;
  logic             serialDataOut;
  logic [WIDTH-1:0] parallelDataOut;
  logic [WIDTH-1:0] rxData;
  logic             busy;
  logic             done;
  spi_dbg_t         dbg;

  modport master (
    output start, parallelDataIn, sampleEdge, launchEdge, serialDataIn,
    input  serialDataOut, parallelDataOut, rxData, busy, done, dbg
  );

  modport slave (
    input  start, parallelDataIn, sampleEdge, launchEdge, serialDataIn,
    output serialDataOut, parallelDataOut, rxData, busy, done, dbg
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Frame bit counter: synchronous clear, increment enable, and a terminal flag
// that marks the increment which completes the frame.
module spi_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         inc,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         terminal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates at WIDTH so a stray increment can never wrap the count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CW'(WIDTH))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = inc && (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_shift_engine.sv
// Parametrised SPI frame shift engine: loads a transmit word, shifts it out
// in the configured bit order while capturing the same number of rx bits.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                reset,
  spi_shift_engine_if.slave   bus
);

  localparam int  CW       = $clog2(WIDTH + 1);
  localparam bit  LSB_MODE = (LSB_FIRST == LSB_FIRST_ORDER);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_d;
  logic             sdo_q;
  logic             sdo_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             accept_start;
  logic             do_sample;
  logic             last_sample;
  logic [CW-1:0]    bit_count;
  logic [WIDTH-1:0] shifted;
  logic             first_bit;
  logic             launch_bit;

  assign accept_start = (state_q == IDLE) && bus.start;
  assign do_sample    = (state_q == ACTIVE) && bus.sampleEdge;

  spi_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept_start),
    .inc      (do_sample),
    .count    (bit_count),
    .terminal (last_sample)
  );

  // The received bit enters at the end opposite to the one being transmitted.
  assign shifted    = LSB_MODE ? {bus.serialDataIn, shift_q[WIDTH-1:1]}
                               : {shift_q[WIDTH-2:0], bus.serialDataIn};
  assign first_bit  = LSB_MODE ? bus.parallelDataIn[0] : bus.parallelDataIn[WIDTH-1];
  assign launch_bit = LSB_MODE ? shift_q[0] : shift_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ACTIVE;
      ACTIVE:  if (do_sample && last_sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample wins over launch in the same cycle; starts during ACTIVE fall
  // through untouched, including on the completing sample.
  always_comb begin
    shift_d = shift_q;
    rx_d    = rx_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.parallelDataIn;
          sdo_d   = first_bit;
          busy_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.sampleEdge) begin
          shift_d = shifted;
          if (last_sample) begin
            rx_d   = shifted;
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end else if (bus.launchEdge) begin
          sdo_d = launch_bit;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      rx_q    <= '0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rx_q    <= rx_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.serialDataOut   = sdo_q;
  assign bus.parallelDataOut = shift_q;
  assign bus.rxData          = rx_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.dbg             = '{state: state_q, bit_count: DBG_COUNT_W'(bit_count)};

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: three instances (8-bit MSB, 8-bit LSB, 16-bit
// MSB), table-driven frames, directed corner cases and a random phase.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int NI = 3;
  localparam int W_C   [NI] = '{8, 8, 16};
  localparam int LSB_C [NI] = '{0, 1, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus and observed outputs ----------------
  logic        start_v  [NI];
  logic        sample_v [NI];
  logic        launch_v [NI];
  logic        sdi_v    [NI];
  logic [31:0] pdi_v    [NI];

  logic        sdo_o  [NI];
  logic        busy_o [NI];
  logic        done_o [NI];
  logic        st_o   [NI];
  logic [31:0] pdo_o  [NI];
  logic [31:0] rx_o   [NI];

  spi_shift_engine_if #(.WIDTH(8))  if0 ();
  spi_shift_engine_if #(.WIDTH(8))  if1 ();
  spi_shift_engine_if #(.WIDTH(16)) if2 ();

  spi_shift_engine #(.WIDTH(8),  .LSB_FIRST(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  spi_shift_engine #(.WIDTH(8),  .LSB_FIRST(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));
  spi_shift_engine #(.WIDTH(16), .LSB_FIRST(0)) dut2 (.clk(clk), .reset(rst), .bus(if2));

  assign if0.start = start_v[0];  assign if0.parallelDataIn = pdi_v[0][7:0];
  assign if0.sampleEdge = sample_v[0]; assign if0.launchEdge = launch_v[0];
  assign if0.serialDataIn = sdi_v[0];
  assign if1.start = start_v[1];  assign if1.parallelDataIn = pdi_v[1][7:0];
  assign if1.sampleEdge = sample_v[1]; assign if1.launchEdge = launch_v[1];
  assign if1.serialDataIn = sdi_v[1];
  assign if2.start = start_v[2];  assign if2.parallelDataIn = pdi_v[2][15:0];
  assign if2.sampleEdge = sample_v[2]; assign if2.launchEdge = launch_v[2];
  assign if2.serialDataIn = sdi_v[2];

  assign sdo_o[0] = if0.serialDataOut; assign busy_o[0] = if0.busy; assign done_o[0] = if0.done;
  assign sdo_o[1] = if1.serialDataOut; assign busy_o[1] = if1.busy; assign done_o[1] = if1.done;
  assign sdo_o[2] = if2.serialDataOut; assign busy_o[2] = if2.busy; assign done_o[2] = if2.done;
  assign st_o[0] = if0.dbg.state; assign st_o[1] = if1.dbg.state; assign st_o[2] = if2.dbg.state;
  assign pdo_o[0] = {24'd0, if0.parallelDataOut}; assign rx_o[0] = {24'd0, if0.rxData};
  assign pdo_o[1] = {24'd0, if1.parallelDataOut}; assign rx_o[1] = {24'd0, if1.rxData};
  assign pdo_o[2] = {16'd0, if2.parallelDataOut}; assign rx_o[2] = {16'd0, if2.rxData};

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_done [NI] = '{0, 0, 0};
  bit chk_en = 1'b0;

  logic        m_busy [NI];
  logic        m_sdo  [NI];
  logic        m_done [NI];
  int          m_k    [NI];
  logic [31:0] m_tx   [NI];
  logic [31:0] m_rxm  [NI];
  logic [31:0] m_rxl  [NI];
  logic [31:0] m_pdo  [NI];
  logic [31:0] m_rx   [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int i);
    return (W_C[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << W_C[i]) - 32'd1);
  endfunction

  // k-th bit on the wire of the transmit word, counting from the first one sent.
  function automatic logic tx_bit(input int i, input int k);
    logic [31:0] t;
    t = m_tx[i];
    return (LSB_C[i] != 0) ? t[k] : t[W_C[i] - 1 - k];
  endfunction

  // Frame-level model: k counts received bits; the live register is the
  // unsent part of the transmit word merged with the bits received so far.
  task automatic model_step(input int i);
    int w;
    w = W_C[i];
    if (rst) begin
      m_busy[i] = 1'b0; m_sdo[i] = 1'b0; m_done[i] = 1'b0; m_k[i] = 0;
      m_tx[i] = '0; m_rxm[i] = '0; m_rxl[i] = '0; m_pdo[i] = '0; m_rx[i] = '0;
      return;
    end
    m_done[i] = 1'b0;
    if (!m_busy[i]) begin
      if (start_v[i]) begin
        m_busy[i] = 1'b1;
        m_k[i]    = 0;
        m_tx[i]   = pdi_v[i] & mask_of(i);
        m_rxm[i]  = '0;
        m_rxl[i]  = '0;
        m_pdo[i]  = m_tx[i];
        m_sdo[i]  = tx_bit(i, 0);
      end
    end else if (sample_v[i]) begin
      m_rxm[i] = (m_rxm[i] << 1) | {31'd0, sdi_v[i]};
      m_rxl[i] = m_rxl[i] | ({31'd0, sdi_v[i]} << m_k[i]);
      m_k[i]++;
      if (LSB_C[i] != 0)
        m_pdo[i] = ((m_tx[i] >> m_k[i]) | (m_rxl[i] << (w - m_k[i]))) & mask_of(i);
      else
        m_pdo[i] = ((m_tx[i] << m_k[i]) | m_rxm[i]) & mask_of(i);
      if (m_k[i] == w) begin
        m_rx[i]   = m_pdo[i];
        m_done[i] = 1'b1;
        m_busy[i] = 1'b0;
      end
    end else if (launch_v[i]) begin
      m_sdo[i] = tx_bit(i, m_k[i]);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model_sdo[%0d]", i),  {31'd0, sdo_o[i]},  {31'd0, m_sdo[i]});
      check($sformatf("model_busy[%0d]", i), {31'd0, busy_o[i]}, {31'd0, m_busy[i]});
      check($sformatf("model_done[%0d]", i), {31'd0, done_o[i]}, {31'd0, m_done[i]});
      check($sformatf("model_state[%0d]", i), {31'd0, st_o[i]},  {31'd0, m_busy[i]});
      check($sformatf("model_pdo[%0d]", i),  pdo_o[i], m_pdo[i]);
      check($sformatf("model_rx[%0d]", i),   rx_o[i],  m_rx[i]);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    if (chk_en) compare_all();
    for (int i = 0; i < NI; i++) if (done_o[i]) n_done[i]++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; sample_v[i] = 1'b0; launch_v[i] = 1'b0;
      sdi_v[i] = 1'b0; pdi_v[i] = '0;
    end
  endtask

  task automatic do_sample(input int i, input logic bit_in, input logic with_start);
    sdi_v[i] = bit_in; sample_v[i] = 1'b1; start_v[i] = with_start;
    cycle();
    sample_v[i] = 1'b0; start_v[i] = 1'b0;
  endtask

  // Start, then launch/sample alternately WIDTH times; the sdo seen after each
  // launch is packed with bit b = b-th bit on the wire.
  task automatic run_frame(input int i, input logic [31:0] pdi, input logic [31:0] sdi_word,
                           input logic [31:0] exp_seq, input logic [31:0] exp_rx, input string tag);
    int w;
    logic [31:0] seq;
    w = W_C[i];
    seq = '0;
    start_v[i] = 1'b1; pdi_v[i] = pdi;
    cycle();
    start_v[i] = 1'b0;
    check({tag, ".busy_after_start"}, {31'd0, busy_o[i]}, 32'd1);
    check({tag, ".done_after_start"}, {31'd0, done_o[i]}, 32'd0);
    check({tag, ".first_sdo"},        {31'd0, sdo_o[i]},  {31'd0, exp_seq[0]});
    for (int b = 0; b < w; b++) begin
      launch_v[i] = 1'b1;
      cycle();
      launch_v[i] = 1'b0;
      seq[b] = sdo_o[i];
      do_sample(i, (LSB_C[i] != 0) ? sdi_word[b] : sdi_word[w - 1 - b], 1'b0);
    end
    check({tag, ".sdo_seq"},  seq, exp_seq);
    check({tag, ".done"},     {31'd0, done_o[i]}, 32'd1);
    check({tag, ".busy_end"}, {31'd0, busy_o[i]}, 32'd0);
    check({tag, ".rx"},       rx_o[i], exp_rx);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int          inst;
    logic [31:0] pdi;
    logic [31:0] sdi_word;
    logic [31:0] exp_seq;
    logic [31:0] exp_rx;
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    int d2;
    vecs[0] = '{inst: 0, pdi: 32'hC4,   sdi_word: 32'h3C,   exp_seq: 32'h23,   exp_rx: 32'h3C};
    vecs[1] = '{inst: 1, pdi: 32'hC4,   sdi_word: 32'h3C,   exp_seq: 32'hC4,   exp_rx: 32'h3C};
    vecs[2] = '{inst: 2, pdi: 32'hBEEF, sdi_word: 32'h1234, exp_seq: 32'hF77D, exp_rx: 32'h1234};
    vecs[3] = '{inst: 2, pdi: 32'h0001, sdi_word: 32'hFFFF, exp_seq: 32'h8000, exp_rx: 32'hFFFF};

    clear_inputs();
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 1'b0; m_sdo[i] = 1'b0; m_done[i] = 1'b0; m_k[i] = 0;
      m_tx[i] = '0; m_rxm[i] = '0; m_rxl[i] = '0; m_pdo[i] = '0; m_rx[i] = '0;
    end
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset.busy[%0d]", i), {31'd0, busy_o[i]}, 32'd0);
      check($sformatf("reset.sdo[%0d]", i),  {31'd0, sdo_o[i]},  32'd0);
      check($sformatf("reset.pdo[%0d]", i),  pdo_o[i], 32'd0);
      check($sformatf("reset.rx[%0d]", i),   rx_o[i],  32'd0);
    end

    // Table frames; rows 2 and 3 run back to back, the second start landing on done.
    d2 = n_done[2];
    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].inst, vecs[v].pdi, vecs[v].sdi_word, vecs[v].exp_seq,
                vecs[v].exp_rx, $sformatf("vec%0d", v));
    check("w16.done_pulses", n_done[2] - d2, 32'd2);

    // start while busy and on the completing sample are both ignored.
    start_v[0] = 1'b1; pdi_v[0] = 32'hFF;
    cycle();
    start_v[0] = 1'b0;
    for (int s = 0; s < 3; s++) do_sample(0, 1'b1, 1'b0);
    start_v[0] = 1'b1; pdi_v[0] = 32'h00;
    cycle();
    start_v[0] = 1'b0;
    check("busy_start.busy", {31'd0, busy_o[0]}, 32'd1);
    check("busy_start.pdo",  pdo_o[0], 32'hFF);
    for (int s = 0; s < 4; s++) begin
      launch_v[0] = 1'b1;
      cycle();
      launch_v[0] = 1'b0;
      check("busy_start.sdo", {31'd0, sdo_o[0]}, 32'd1);
      do_sample(0, 1'b1, 1'b0);
    end
    do_sample(0, 1'b1, 1'b1);
    check("busy_start.done", {31'd0, done_o[0]}, 32'd1);
    check("busy_start.rx",   rx_o[0], 32'hFF);
    cycle();
    check("done_cycle_start.busy", {31'd0, busy_o[0]}, 32'd0);

    // Reset mid-frame clears everything, then a clean frame follows.
    start_v[0] = 1'b1; pdi_v[0] = 32'hA5;
    cycle();
    start_v[0] = 1'b0;
    for (int s = 0; s < 4; s++) do_sample(0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midreset.busy", {31'd0, busy_o[0]}, 32'd0);
    check("midreset.done", {31'd0, done_o[0]}, 32'd0);
    check("midreset.sdo",  {31'd0, sdo_o[0]},  32'd0);
    check("midreset.pdo",  pdo_o[0], 32'd0);
    check("midreset.rx",   rx_o[0],  32'd0);
    run_frame(0, 32'hA5, 32'h5A, 32'hA5, 32'h5A, "after_reset");

    // Strobes in IDLE change nothing.
    for (int t = 0; t < 10; t++) begin
      sdi_v[0] = 1'b1; sample_v[0] = 1'b1;
      cycle();
      sample_v[0] = 1'b0; launch_v[0] = 1'b1;
      cycle();
      launch_v[0] = 1'b0;
    end
    check("idle_strobe.pdo",  pdo_o[0], 32'h5A);
    check("idle_strobe.sdo",  {31'd0, sdo_o[0]}, 32'd1);
    check("idle_strobe.busy", {31'd0, busy_o[0]}, 32'd0);

    // Same-cycle sample and launch: shift happens, launch is dropped.
    start_v[0] = 1'b1; pdi_v[0] = 32'h40;
    cycle();
    start_v[0] = 1'b0;
    check("both.first_sdo", {31'd0, sdo_o[0]}, 32'd0);
    do_sample(0, 1'b0, 1'b0);
    check("both.pdo1", pdo_o[0], 32'h80);
    launch_v[0] = 1'b1;
    do_sample(0, 1'b0, 1'b0);
    launch_v[0] = 1'b0;
    check("both.sdo", {31'd0, sdo_o[0]}, 32'd0);
    check("both.pdo2", pdo_o[0], 32'h00);
    for (int s = 0; s < 6; s++) do_sample(0, 1'b0, 1'b0);
    check("both.done", {31'd0, done_o[0]}, 32'd1);
    check("both.rx",   rx_o[0], 32'h00);

    // Random phase against the model on all three instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        start_v[i]  = ($urandom_range(0, 7) == 0);
        pdi_v[i]    = $urandom;
        sample_v[i] = ($urandom_range(0, 2) == 0);
        launch_v[i] = ($urandom_range(0, 2) == 0);
        sdi_v[i]    = $urandom_range(0, 1) == 1;
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    clear_inputs();
    rst = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised frame-level shift engine for the SPI peripheral datapath, successor to the fixed 8-bit shift register. It loads a transmit word, shifts it out MSB- or LSB-first, captures the same number of received bits and latches the completed receive word. It sits between the SPI edge detector, which supplies the sample/launch strobes, and the register/FSM layer, which drives the start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, frame length in bits; legal range 2..32
- LSB_FIRST, 0, 0 = MSB transmitted/received first, 1 = LSB first

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; accepted only in IDLE
- parallelDataIn  in  WIDTH  transmit word, sampled on the accepted start
- sampleEdge  in  1  one-cycle strobe: capture serialDataIn
- launchEdge  in  1  one-cycle strobe: advance serialDataOut
- serialDataIn  in  1  received serial bit
- serialDataOut  out  1  transmitted serial bit, registered
- parallelDataOut  out  WIDTH  live shift-register contents
- rxData  out  WIDTH  last completed receive word, held until the next completion
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, ACTIVE. Encoding is 1 bit.
- Reset: state IDLE; shift register, rxData, serialDataOut, bit counter, busy and done all cleared to 0.
- IDLE + start:
  - shift register <= parallelDataIn
  - serialDataOut <= parallelDataIn[WIDTH-1] (MSB-first) or parallelDataIn[0] (LSB-first)
  - counter <= 0; busy <= 1; state <= ACTIVE
- ACTIVE + sampleEdge:
  - MSB-first: register <= {reg[WIDTH-2:0], serialDataIn}
  - LSB-first: register <= {serialDataIn, reg[WIDTH-1:1]}
  - counter increments
- ACTIVE + launchEdge (without sampleEdge): serialDataOut <= reg[WIDTH-1] (MSB-first) or reg[0] (LSB-first).
- Completion: the sampleEdge that brings the counter to WIDTH also does the following in the same clock:
  - rxData <= the post-shift register value
  - done <= 1 for exactly one cycle
  - busy <= 0; state <= IDLE
- Counter width is $clog2(WIDTH+1). It never exceeds WIDTH and is cleared on start.
- Boundary rules:
  - start while ACTIVE, including the completion cycle: ignored, no state change.
  - start in the cycle after done: accepted.
  - sampleEdge and launchEdge in the same cycle: the sample is performed and the launch is dropped.
  - sampleEdge or launchEdge in IDLE: ignored; register and serialDataOut hold.
  - reset mid-frame: returns all state to reset values. done is not asserted and rxData is cleared.
  - serialDataOut holds its last value in IDLE.

## Timing
- start in cycle n: busy = 1 and serialDataOut = first bit from cycle n+1.
- sampleEdge in cycle n: parallelDataOut updated from cycle n+1.
- Final sampleEdge in cycle n: done = 1, busy = 0 and rxData valid in cycle n+1. done = 0 in cycle n+2.
- launchEdge in cycle n: new serialDataOut visible from cycle n+1.
- No combinational path from any input to any output. All outputs are registered.
- Minimum frame: WIDTH sampleEdges. Strobes may be back-to-back on consecutive cycles.

## Structure
- Shared package spi_pkg holds:
  - the state localparams (IDLE = 1'b0, ACTIVE = 1'b1)
  - the bit-order constants MSB_FIRST = 0 and LSB_FIRST_ORDER = 1
  These are shared with the SPI FSM.
- One sub-module, spi_bit_counter: parametrised WIDTH counter with sync clear, increment enable and a terminal flag (count == WIDTH-1 with increment asserted).
- The shift register, output bit register and state register stay in spi_shift_engine.

## Test plan
- WIDTH=8, MSB-first, start with 0xC4, serialDataIn stream 0x3C (MSB first), alternating launch then sample ×8 -> serialDataOut sequence 1,1,0,0,0,1,0,0; rxData = 0x3C; done is high for one cycle, the cycle after the 8th sample; busy is low the same cycle.
- WIDTH=8, LSB_FIRST=1, start with 0xC4, serialDataIn bits of 0x3C bit0 first -> serialDataOut sequence 0,0,1,0,0,0,1,1; rxData = 0x3C.
- start 0xFF, then 3 samples, then start with 0x00 while busy -> the second start is ignored; the frame completes after 5 more samples with the original transmit bits.
- Assert reset after 4 samples -> busy, done, rxData, serialDataOut and parallelDataOut are all 0 next cycle; a following start with 0xA5 runs a clean 8-bit frame.
- In IDLE, toggle sampleEdge/launchEdge 10× with serialDataIn=1 -> parallelDataOut and serialDataOut unchanged. Same-cycle sample+launch inside a frame -> only the shift occurs.
- WIDTH=16, start with 0xBEEF, 16 samples of 0x1234 -> rxData = 0x1234. Done is asserted exactly once; back-to-back start the next cycle is accepted.
